// File: rtl/matrix_scanner.sv
// matrix_scanner: column-multiplexed driver for a 5x7 active-low LED matrix.
// A valid/ready handshake fills a shadow buffer. The shadow is promoted to the
// displayed buffer only at a frame boundary, so a frame is never torn.
// A short blanking gap separates columns to suppress ghosting.
// Optional feature: define BLINK_EN to add a 'blink' input and BLINK_FRAMES parameter.
module matrix_scanner #(
  parameter int DATA_WIDTH    = 35,
  parameter int COLUNE_SIZE   = 7,
  parameter int TOTAL_COLUNES = 5,
  parameter int DIV_WIDTH     = 16,
  parameter int SCAN_DIV      = 50000,
`ifdef BLINK_EN
  parameter int BLINK_FRAMES  = 32,
`endif
  parameter int BLANK_CYCLES  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef BLINK_EN
  input  logic                     blink,
`endif
  input  logic [DATA_WIDTH-1:0]    frameIn,
  input  logic                     frame_valid,
  output logic                     frame_ready,
  output logic [TOTAL_COLUNES-1:0] colOut,
  output logic [COLUNE_SIZE-1:0]   rowOut,
  output logic                     frame_done
);

  localparam int COL_W = (TOTAL_COLUNES > 1) ? $clog2(TOTAL_COLUNES) : 1;
  localparam logic [DIV_WIDTH-1:0] SCAN_LAST  = DIV_WIDTH'(SCAN_DIV - 1);
  localparam logic [DIV_WIDTH-1:0] BLANK_LAST = DIV_WIDTH'(BLANK_CYCLES - 1);
  localparam logic [COL_W-1:0]     COL_LAST   = COL_W'(TOTAL_COLUNES - 1);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t                   state, state_next;
  logic [COL_W-1:0]         col, col_next;
  logic [DIV_WIDTH-1:0]     cnt, cnt_next;
  logic                     boundary;

  logic [DATA_WIDTH-1:0]    shadow;
  logic [DATA_WIDTH-1:0]    active;
  logic                     pending;
  logic                     wrapped;

  logic [COLUNE_SIZE-1:0]   slice;
  logic [TOTAL_COLUNES-1:0] col_onehot;
  logic                     display_on;

  // Scan state register: BLANK/DRIVE phase, current column and dwell counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BLANK;
      col   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      col   <= col_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic; the dwell counter restarts whenever the phase changes,
  // and leaving DRIVE on the last column marks the frame boundary
  always_comb begin
    state_next = state;
    col_next   = col;
    cnt_next   = cnt + 1'b1;
    boundary   = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_next = DRIVE;
          cnt_next   = '0;
        end
      end
      DRIVE: begin
        if (cnt == SCAN_LAST) begin
          state_next = BLANK;
          cnt_next   = '0;
          if (col == COL_LAST) begin
            col_next = '0;
            boundary = 1'b1;
          end else begin
            col_next = col + 1'b1;
          end
        end
      end
      default: begin
        state_next = BLANK;
        cnt_next   = '0;
      end
    endcase
  end

  // Double buffer: accept into the shadow when free, promote it only at a boundary.
  // A load landing on the boundary edge sees pending=0, so it waits a full frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow  <= '1;
      active  <= '1;
      pending <= 1'b0;
    end else begin
      if (boundary && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      if (frame_valid && !pending) begin
        shadow  <= frameIn;
        pending <= 1'b1;
      end
    end
  end

  assign frame_ready = ~pending;

`ifdef BLINK_EN
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic               phase_on;

  // Blink phase: flips every BLINK_FRAMES boundaries while blink is held high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (!blink) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (boundary) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase_on  <= ~phase_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign display_on = phase_on;
`else
  assign display_on = 1'b1;
`endif

  // Column slice of the displayed buffer and the one-hot column select
  always_comb begin
    slice      = '1;
    col_onehot = '0;
    for (int c = 0; c < TOTAL_COLUNES; c++) begin
      if (col == COL_W'(c)) begin
        slice         = active[c*COLUNE_SIZE +: COLUNE_SIZE];
        col_onehot[c] = 1'b1;
      end
    end
  end

  // Registered pin drivers; frame_done lags the boundary so it marks the
  // first cycle of the new frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      colOut     <= '0;
      rowOut     <= '1;
      wrapped    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      wrapped    <= boundary;
      frame_done <= wrapped;
      if (state == DRIVE) begin
        colOut <= col_onehot;
        rowOut <= display_on ? slice : '1;
      end else begin
        colOut <= '0;
        rowOut <= '1;
      end
    end
  end

endmodule
